spi_dac_rx: RTL and testbench

- DAC-side responder for the waveform generator's 4-wire DAC link (CS, SPI clock, SDI, LDAC), in MCP4922 frame format.
- Oversamples the link in the CLK100 domain and decodes 16-bit frames into per-channel input latches.
- Transfers the latches to output registers under LDAC control.
- Used for on-chip loopback capture and as a synthesizable DAC model for verifying the wavegen SPI initiator.

---
 rtl/wavegen_dac_pkg.sv | 25 ++
 rtl/spi_dac_rx_sync_edge.sv | 31 +++
 rtl/spi_dac_rx.sv | 156 +++++++++++++++
 tb/tb_spi_dac_rx.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wavegen_dac_pkg.sv
// Shared types for the wavegen DAC link: MCP4922 frame layout and receiver FSM states.
package wavegen_dac_pkg;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;

    typedef struct packed {
        logic                 ab;
        logic                 buf_en;
        logic                 ga_n;
        logic                 shdn_n;
        logic [DATA_BITS-1:0] code;
    } dac_frame_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } rx_state_t;

    function automatic logic [2:0] frame_cfg(input dac_frame_t f);
        return {f.buf_en, f.ga_n, f.shdn_n};
    endfunction

endpackage

// File: rtl/spi_dac_rx_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with level and single-cycle edge outputs.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;

endmodule

// File: rtl/spi_dac_rx.sv
// MCP4922-format SPI responder: oversamples CS/SCLK/SDI/LDAC in the CLK100 domain,
// decodes 16-bit frames into per-channel input latches and transfers them under LDAC.
module spi_dac_rx
    import wavegen_dac_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = wavegen_dac_pkg::FRAME_BITS,
    parameter int DATA_BITS   = wavegen_dac_pkg::DATA_BITS
) (
    input  logic                 CLK100,
    input  logic                 RESET_N,
    input  logic                 CS,
    input  logic                 SCLK,
    input  logic                 SDI,
    input  logic                 LDAC,
    output logic [DATA_BITS-1:0] DAC_A,
    output logic [DATA_BITS-1:0] DAC_B,
    output logic [2:0]           CFG_A,
    output logic [2:0]           CFG_B,
    output logic                 FRAME_VALID,
    output logic                 FRAME_ERR,
    output logic                 UPDATE
);

    localparam int CW = $clog2(FRAME_BITS + 2);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;

    logic                  w_cs_level, w_cs_rise, w_cs_fall;
    logic                  w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic                  w_sdi_level, w_sdi_rise, w_sdi_fall;
    logic                  w_ldac_level, w_ldac_rise, w_ldac_fall;

    rx_state_t             r_state, w_next;
    logic                  r_cs_pend;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CW-1:0]         r_count;
    dac_frame_t            w_frame;
    logic                  w_xfer;

    logic [DATA_BITS-1:0]  r_lat_a_code, r_lat_b_code;
    logic [2:0]            r_lat_a_cfg, r_lat_b_cfg;
    logic [DATA_BITS-1:0]  r_dac_a, r_dac_b;
    logic [2:0]            r_cfg_a, r_cfg_b;
    logic                  r_frame_valid, r_frame_err, r_update;

    // Reset asserts asynchronously, releases on a CLK100 edge.
    always_ff @(posedge CLK100 or negedge RESET_N) begin
        if (!RESET_N) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs (
        .clk(CLK100), .rst_n(w_rst_n), .i_d(CS),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk (
        .clk(CLK100), .rst_n(w_rst_n), .i_d(SCLK),
        .o_level(w_sclk_level), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sdi (
        .clk(CLK100), .rst_n(w_rst_n), .i_d(SDI),
        .o_level(w_sdi_level), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );
    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ldac (
        .clk(CLK100), .rst_n(w_rst_n), .i_d(LDAC),
        .o_level(w_ldac_level), .o_rise(w_ldac_rise), .o_fall(w_ldac_fall)
    );

    always_ff @(posedge CLK100 or negedge w_rst_n) begin
        if (!w_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall || r_cs_pend) w_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_next = COMMIT;
            COMMIT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_frame = dac_frame_t'(r_shift);
    assign w_xfer  = w_ldac_fall | (r_frame_valid & ~w_ldac_level);

    always_ff @(posedge CLK100 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cs_pend     <= 1'b0;
            r_shift       <= '0;
            r_count       <= '0;
            r_lat_a_code  <= '0;
            r_lat_b_code  <= '0;
            r_lat_a_cfg   <= '0;
            r_lat_b_cfg   <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            // A CS fall seen during COMMIT is held so IDLE can still start the frame.
            r_cs_pend     <= w_cs_fall && (r_state == COMMIT);
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
            if (r_state == IDLE && w_next == SHIFT) begin
                r_shift <= '0;
                r_count <= '0;
            end else if (r_state == SHIFT && w_sclk_rise) begin
                r_shift <= {r_shift[FRAME_BITS-2:0], w_sdi_level};
                if (r_count != CW'(FRAME_BITS + 1)) r_count <= r_count + 1'b1;
            end
            if (r_state == COMMIT) begin
                if (r_count == CW'(FRAME_BITS)) begin
                    r_frame_valid <= 1'b1;
                    if (w_frame.ab) begin
                        r_lat_b_code <= w_frame.code;
                        r_lat_b_cfg  <= frame_cfg(w_frame);
                    end else begin
                        r_lat_a_code <= w_frame.code;
                        r_lat_a_cfg  <= frame_cfg(w_frame);
                    end
                end else begin
                    r_frame_err <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK100 or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_dac_a  <= '0;
            r_dac_b  <= '0;
            r_cfg_a  <= '0;
            r_cfg_b  <= '0;
            r_update <= 1'b0;
        end else begin
            r_update <= w_xfer;
            if (w_xfer) begin
                r_dac_a <= r_lat_a_code;
                r_dac_b <= r_lat_b_code;
                r_cfg_a <= r_lat_a_cfg;
                r_cfg_b <= r_lat_b_cfg;
            end
        end
    end

    assign DAC_A       = r_dac_a;
    assign DAC_B       = r_dac_b;
    assign CFG_A       = r_cfg_a;
    assign CFG_B       = r_cfg_b;
    assign FRAME_VALID = r_frame_valid;
    assign FRAME_ERR   = r_frame_err;
    assign UPDATE      = r_update;

endmodule

// File: tb/tb_spi_dac_rx.sv
// Self-checking bench for spi_dac_rx: directed scenarios plus random frames against a frame-level model.
module tb_spi_dac_rx;

    localparam int SYNC_STAGES = 2;

    logic        CLK100 = 1'b0;
    logic        RESET_N, CS, SCLK, SDI, LDAC;
    logic [11:0] DAC_A, DAC_B;
    logic [2:0]  CFG_A, CFG_B;
    logic        FRAME_VALID, FRAME_ERR, UPDATE;

    spi_dac_rx #(.SYNC_STAGES(SYNC_STAGES), .FRAME_BITS(16), .DATA_BITS(12)) dut (
        .CLK100(CLK100), .RESET_N(RESET_N), .CS(CS), .SCLK(SCLK), .SDI(SDI), .LDAC(LDAC),
        .DAC_A(DAC_A), .DAC_B(DAC_B), .CFG_A(CFG_A), .CFG_B(CFG_B),
        .FRAME_VALID(FRAME_VALID), .FRAME_ERR(FRAME_ERR), .UPDATE(UPDATE)
    );

    always #5 CLK100 = ~CLK100;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int nv = 0, ne = 0, nu = 0;
    int t_valid = 0, t_upd = 0, t_cs = 0;
    int ev = 0, ee = 0, eu = 0;

    // Model: whole 16-bit frames held per channel (index 0 = A, 1 = B).
    logic [15:0] m_lat [2];
    logic [15:0] m_out [2];

    always @(posedge CLK100) cyc <= cyc + 1;

    always @(negedge CLK100) begin
        if (FRAME_VALID) begin nv++; t_valid = cyc; end
        if (FRAME_ERR) ne++;
        if (UPDATE) begin nu++; t_upd = cyc; end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge CLK100);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dac_a"}, 32'(DAC_A), 32'(m_out[0][11:0]));
        chk({tag, ".cfg_a"}, 32'(CFG_A), 32'(m_out[0][14:12]));
        chk({tag, ".dac_b"}, 32'(DAC_B), 32'(m_out[1][11:0]));
        chk({tag, ".cfg_b"}, 32'(CFG_B), 32'(m_out[1][14:12]));
        chk({tag, ".n_valid"}, nv, ev);
        chk({tag, ".n_err"}, ne, ee);
        chk({tag, ".n_update"}, nu, eu);
    endtask

    task automatic model_reset();
        m_lat[0] = '0; m_lat[1] = '0;
        m_out[0] = '0; m_out[1] = '0;
    endtask

    task automatic model_frame(input logic [16:0] f, input int n);
        if (n == 16) begin
            m_lat[f[15]] = f[15:0];
            ev++;
            if (!LDAC) begin
                m_out[0] = m_lat[0];
                m_out[1] = m_lat[1];
                eu++;
            end
        end else begin
            ee++;
        end
    endtask

    task automatic ldac_set(input logic v);
        if (LDAC && !v) begin
            m_out[0] = m_lat[0];
            m_out[1] = m_lat[1];
            eu++;
        end
        LDAC = v;
        clk_wait(6);
    endtask

    task automatic shift_bits(input logic [16:0] f, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            SDI = f[i];
            clk_wait(4);
            SCLK = 1'b1;
            clk_wait(4);
            SCLK = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [16:0] f, input int n, input int gap);
        CS = 1'b0;
        clk_wait(4);
        shift_bits(f, n);
        clk_wait(4);
        CS = 1'b1;
        t_cs = cyc;
        model_frame(f, n);
        clk_wait(gap);
    endtask

    initial begin
        int          r, n;
        logic [16:0] f;

        RESET_N = 1'b0; CS = 1'b1; SCLK = 1'b0; SDI = 1'b0; LDAC = 1'b1;
        model_reset();
        clk_wait(3);
        RESET_N = 1'b1;
        clk_wait(6);
        check_all("reset");

        for (int i = 0; i < 25; i++) begin
            SCLK = ~SCLK;
            clk_wait(4);
        end
        SCLK = 1'b0;
        clk_wait(4);
        check_all("idle_sclk");

        send_frame(17'h03ABC, 16, 10);
        check_all("a_ldac_high");
        ldac_set(1'b0);
        ldac_set(1'b1);
        check_all("a_ldac_pulse");

        ldac_set(1'b0);
        send_frame(17'h0F123, 16, 10);
        check_all("b_transparent");
        chk("b_valid_latency", t_valid - t_cs, SYNC_STAGES + 2);
        chk("b_update_latency", t_upd - t_valid, 1);
        ldac_set(1'b1);

        send_frame(17'h00555, 15, 10);
        check_all("short_frame");
        send_frame(17'h1A5A5, 17, 10);
        check_all("long_frame");
        CS = 1'b0;
        clk_wait(6);
        CS = 1'b1;
        ee++;
        clk_wait(10);
        check_all("cs_glitch");

        send_frame(17'h02468, 16, 3);
        send_frame(17'h09BDF, 16, 10);
        check_all("b2b_latched");
        ldac_set(1'b0);
        ldac_set(1'b1);
        check_all("b2b_update");

        CS = 1'b0;
        clk_wait(4);
        shift_bits(17'h0AAAA, 8);
        RESET_N = 1'b0;
        #1;
        model_reset();
        check_all("reset_midframe");
        CS = 1'b1; SCLK = 1'b0;
        clk_wait(3);
        RESET_N = 1'b1;
        clk_wait(6);
        send_frame(17'h01FFF, 16, 10);
        ldac_set(1'b0);
        ldac_set(1'b1);
        check_all("after_reset_frame");

        for (int k = 0; k < 24; k++) begin
            r = $urandom_range(0, 7);
            n = (r == 0) ? 15 : ((r == 1) ? 17 : 16);
            f = 17'($urandom);
            if ($urandom_range(0, 3) == 0) ldac_set(~LDAC);
            send_frame(f, n, 10);
            if (LDAC && $urandom_range(0, 1) == 1) begin
                ldac_set(1'b0);
                ldac_set(1'b1);
            end
            check_all("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
